flp_burst_generator: RTL and testbench

Transmit-side link-pulse generator for the 10BASE-T / auto-negotiation path. In NLP mode it emits one normal link pulse per burst period; in FLP mode it emits a fast-link-pulse burst encoding a 16-bit link code word. It is the transmitter counterpart to the receive-side pulse/edge detection logic. It sits between the auto-negotiation control logic (code word, mode, enable) and the PHY pulse driver.

---
 rtl/flp_burst_generator_if.sv | 20 ++
 rtl/flp_burst_generator.sv | 160 ++++++++++++++++
 tb/tb_flp_burst_generator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/flp_burst_generator_if.sv
// Handshake bundle between the auto-negotiation control side and the
// link-pulse generator: control inputs in, registered pulse/burst status out.
interface flp_burst_generator_if;
    logic        enable;
    logic        flp_mode;
    logic [15:0] link_code_word;
    logic        pulse_out;
    logic        burst_active;
    logic        burst_done;

    modport master (
        output enable, flp_mode, link_code_word,
        input  pulse_out, burst_active, burst_done
    );

    modport slave (
        input  enable, flp_mode, link_code_word,
        output pulse_out, burst_active, burst_done
    );
endinterface

// File: rtl/flp_burst_generator.sv
// Transmit link-pulse generator: one NLP per period, or a 33-position FLP burst
// carrying a 16-bit link code word (clock pulses on even slots, data on odd).
module flp_burst_generator #(
    parameter int PULSE_CYCLES        = 5,
    parameter int SLOT_CYCLES         = 3125,
    parameter int BURST_PERIOD_CYCLES = 800000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    flp_burst_generator_if.slave  bus
);
    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int PW = (BURST_PERIOD_CYCLES > 1) ? $clog2(BURST_PERIOD_CYCLES) : 1;
    localparam logic [SW-1:0] PULSE_LAST  = SW'(PULSE_CYCLES - 1);
    localparam logic [SW-1:0] SLOT_LAST   = SW'(SLOT_CYCLES - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(BURST_PERIOD_CYCLES - 1);
    localparam logic [5:0]    FLP_LAST    = 6'd32;

    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP, ST_WAIT} state_e;

    state_e        state_q,  state_d;
    logic [5:0]    pos_q,    pos_d;
    logic [SW-1:0] slot_q,   slot_d;
    logic [PW-1:0] period_q, period_d;
    logic          mode_q,   mode_d;
    logic [15:0]   word_q,   word_d;
    logic          pulse_q,  pulse_d;
    logic          active_q, active_d;
    logic          done_q,   done_d;
    logic          start_s;
    logic [5:0]    last_pos_s;

    // Even positions are clock pulses; odd position 2k+1 carries data bit k.
    function automatic logic slot_has_pulse(input logic [5:0] pos, input logic [15:0] word);
        logic res;
        if (pos[0] == 1'b0) begin
            res = 1'b1;
        end else begin
            res = word[pos[4:1]];
        end
        return res;
    endfunction

    assign last_pos_s = mode_q ? FLP_LAST : 6'd0;

    // Next-state computation for the burst sequencer and its registered outputs.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        slot_d   = slot_q;
        period_d = period_q;
        mode_d   = mode_q;
        word_d   = word_q;
        pulse_d  = pulse_q;
        active_d = active_q;
        done_d   = 1'b0;
        start_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                period_d = '0;
                slot_d   = '0;
                if (bus.enable) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_PULSE: begin
                period_d = period_q + PW'(1);
                if (slot_q == PULSE_LAST) begin
                    pulse_d = 1'b0;
                    if (pos_q == last_pos_s) begin
                        active_d = 1'b0;
                        done_d   = 1'b1;
                        slot_d   = '0;
                        state_d  = bus.enable ? ST_WAIT : ST_IDLE;
                    end else begin
                        slot_d  = slot_q + SW'(1);
                        state_d = ST_GAP;
                    end
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            ST_GAP: begin
                period_d = period_q + PW'(1);
                if (slot_q == SLOT_LAST) begin
                    slot_d  = '0;
                    pos_d   = pos_q + 6'd1;
                    pulse_d = slot_has_pulse(pos_q + 6'd1, word_q);
                    state_d = ST_PULSE;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            ST_WAIT: begin
                period_d = period_q + PW'(1);
                if (!bus.enable) begin
                    state_d  = ST_IDLE;
                    period_d = '0;
                end else if (period_q == PERIOD_LAST) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                pulse_d  = 1'b0;
                active_d = 1'b0;
                period_d = '0;
                slot_d   = '0;
            end
        endcase

        // Position 0 is always a clock pulse, so the first pulse starts with the burst.
        if (start_s) begin
            state_d  = ST_PULSE;
            pos_d    = 6'd0;
            slot_d   = '0;
            period_d = '0;
            mode_d   = bus.flp_mode;
            word_d   = bus.link_code_word;
            pulse_d  = 1'b1;
            active_d = 1'b1;
        end else begin
            mode_d = mode_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pos_q    <= 6'd0;
            slot_q   <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            word_q   <= 16'h0000;
            pulse_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            slot_q   <= slot_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            word_q   <= word_d;
            pulse_q  <= pulse_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign bus.pulse_out    = pulse_q;
    assign bus.burst_active = active_q;
    assign bus.burst_done   = done_q;
endmodule

// File: tb/tb_flp_burst_generator.sv
// Directed bench for flp_burst_generator with a cycle-by-cycle expected-waveform
// model of each burst period (PULSE=2, SLOT=8, PERIOD=300).
module tb_flp_burst_generator;
    localparam int PULSE  = 2;
    localparam int SLOT   = 8;
    localparam int PERIOD = 300;

    logic clk;
    logic rst_n;
    int   n_asserts;
    int   n_fail;

    flp_burst_generator_if bus ();

    flp_burst_generator #(
        .PULSE_CYCLES        (PULSE),
        .SLOT_CYCLES         (SLOT),
        .BURST_PERIOD_CYCLES (PERIOD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input int c, input logic got, input logic exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, got, exp);
        end
    endtask

    // Entered at the negedge inside cycle S; leaves at the negedge of cycle S+n.
    // Beyond one period every output is expected low (enable was dropped earlier).
    task automatic run_window(input string tag, input logic m, input logic [15:0] w,
                              input int n, input int drop_at, input int chg_at,
                              input logic nm, input logic [15:0] nw);
        for (int c = 0; c < n; c++) begin
            int   last;
            int   p;
            int   s;
            logic ep;
            logic ea;
            logic ed;
            last = m ? 32 : 0;
            p    = c / SLOT;
            s    = c % SLOT;
            ep   = 1'b0;
            ea   = 1'b0;
            ed   = 1'b0;
            if (c < PERIOD) begin
                if ((p <= last) && (s < PULSE)) begin
                    ep = ((p % 2) == 0) ? 1'b1 : w[(p - 1) / 2];
                end
                ea = (c <= last * SLOT + PULSE - 1);
                ed = (c == last * SLOT + PULSE);
            end
            check_bit({tag, ".pulse_out"},    c, bus.pulse_out,    ep);
            check_bit({tag, ".burst_active"}, c, bus.burst_active, ea);
            check_bit({tag, ".burst_done"},   c, bus.burst_done,   ed);
            if (c == drop_at) begin
                bus.enable = 1'b0;
            end
            if (c == chg_at) begin
                bus.flp_mode       = nm;
                bus.link_code_word = nw;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        clk                = 1'b0;
        rst_n              = 1'b0;
        n_asserts          = 0;
        n_fail             = 0;
        bus.enable         = 1'b0;
        bus.flp_mode       = 1'b0;
        bus.link_code_word = 16'h0000;

        // Reset state and idle with enable low
        repeat (3) @(negedge clk);
        check_bit("reset.pulse_out",    0, bus.pulse_out,    1'b0);
        check_bit("reset.burst_active", 0, bus.burst_active, 1'b0);
        check_bit("reset.burst_done",   0, bus.burst_done,   1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("idle.pulse_out",    0, bus.pulse_out,    1'b0);
        check_bit("idle.burst_active", 0, bus.burst_active, 1'b0);

        // Reset asserted in the middle of a pulse
        bus.enable = 1'b1;
        @(negedge clk);
        check_bit("midrst.pre_pulse", 0, bus.pulse_out, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_bit("midrst.pulse_out",    0, bus.pulse_out,    1'b0);
        check_bit("midrst.burst_active", 0, bus.burst_active, 1'b0);
        bus.enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_bit("postrst.pulse_out", 0, bus.pulse_out, 1'b0);

        // Back-to-back FLP bursts with enable held; next word set after each burst ends
        bus.flp_mode       = 1'b1;
        bus.link_code_word = 16'hA5A5;
        bus.enable         = 1'b1;
        @(negedge clk);
        run_window("flp_a5a5", 1'b1, 16'hA5A5, PERIOD, -1, 260, 1'b1, 16'h0000);
        run_window("flp_0000", 1'b1, 16'h0000, PERIOD, -1, 260, 1'b1, 16'hFFFF);
        // Inputs change at S+50: current burst keeps FFFF, next one is NLP
        run_window("flp_ffff", 1'b1, 16'hFFFF, PERIOD, -1, 50, 1'b0, 16'h1234);
        run_window("nlp_0", 1'b0, 16'h1234, PERIOD, -1, -1, 1'b0, 16'h0000);
        run_window("nlp_1", 1'b0, 16'h1234, PERIOD, -1, -1, 1'b0, 16'h0000);
        run_window("nlp_2", 1'b0, 16'h1234, PERIOD, -1, 10, 1'b1, 16'hA5A5);

        // enable dropped mid-burst: burst completes, no burst at S+300
        run_window("flp_drop", 1'b1, 16'hA5A5, PERIOD + 10, 100, -1, 1'b0, 16'h0000);

        // Reassert from IDLE: S follows the sampling edge; then drop enable in WAIT
        bus.enable   = 1'b1;
        bus.flp_mode = 1'b0;
        @(negedge clk);
        run_window("nlp_restart", 1'b0, 16'hA5A5, PERIOD + 20, 10, -1, 1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
